// File: rtl/axis_framer_pkg.sv
// axis_framer_pkg: state encoding, default sync word and header/trailer field offsets shared with the host parser
package axis_framer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_TRAILER} state_t;
  localparam logic [31:0] SYNC_DEFAULT = 32'hA5C3_0F5A;
  localparam int SYNC_LSB = 0;
  localparam int SEQ_LSB = 32;
  localparam int CHAN_LSB = 48;
  localparam int CNT_LSB = 32;
  localparam int OVF_BIT = 48;
endpackage

// File: rtl/axis_chan_framer_if.sv
// axis_chan_framer_if: one AXI-stream link carrying a binary channel index in tuser
interface axis_chan_framer_if #(
  parameter int NUM_CHAN = 6,
  parameter int DATA_WIDTH = 128
);
  logic tvalid;
  logic tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic tlast;
  logic [NUM_CHAN-1:0] tuser;
  modport master(output tvalid, tdata, tlast, tuser, input tready);
  modport slave(input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/axis_seq_table.sv
// axis_seq_table: per-channel sequence counters; reads of an unknown channel return all-ones and never increment
module axis_seq_table #(
  parameter int NUM_CHAN = 6,
  parameter int SEQ_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CHAN-1:0]  rd_idx,
  output logic [SEQ_WIDTH-1:0] rd_seq,
  input  logic                 inc,
  input  logic [NUM_CHAN-1:0]  inc_idx
);
  logic [SEQ_WIDTH-1:0] seq [NUM_CHAN];
  always_comb begin
    rd_seq = '1;
    for (int i = 0; i < NUM_CHAN; i++) rd_seq = rd_idx == NUM_CHAN'(i) ? seq[i] : rd_seq;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq <= '{default: '0};
    else for (int i = 0; i < NUM_CHAN; i++) if (inc && inc_idx == NUM_CHAN'(i)) seq[i] <= seq[i] + 1'b1;
  end
endmodule

// File: rtl/axis_chan_framer.sv
// axis_chan_framer: wraps each fan-in packet in a sequence-numbered header beat and a count/overflow trailer beat
module axis_chan_framer
  import axis_framer_pkg::*;
#(
  parameter int NUM_CHAN = 6,
  parameter int DATA_WIDTH = 128,
  parameter int SEQ_WIDTH = 16,
  parameter int LEN_WIDTH = 16,
  parameter logic [31:0] SYNC_WORD = SYNC_DEFAULT
) (
  input logic s_axis_clk,
  input logic s_axis_rst_n,
  axis_chan_framer_if.slave s_axis,
  axis_chan_framer_if.master m_axis
);
  state_t state, state_nx;
  logic [NUM_CHAN-1:0] chan, rd_idx, m_user;
  logic [SEQ_WIDTH-1:0] rd_seq;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic ovf, load, hdr_go, acc, trl_go, m_valid, m_last;
  logic [DATA_WIDTH-1:0] m_data, hdr, trl, nx_data;
  assign load = !m_valid || m_axis.tready;
  assign hdr_go = state == ST_IDLE && load && s_axis.tvalid;
  assign acc = state == ST_PAYLOAD && load && s_axis.tvalid;
  assign trl_go = state == ST_TRAILER && load;
  assign s_axis.tready = state == ST_PAYLOAD && load;
  assign rd_idx = state == ST_IDLE ? s_axis.tuser : chan;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata = m_data;
  assign m_axis.tlast = m_last;
  assign m_axis.tuser = m_user;
  axis_seq_table #(.NUM_CHAN(NUM_CHAN), .SEQ_WIDTH(SEQ_WIDTH)) u_seq (
    .clk(s_axis_clk), .rst_n(s_axis_rst_n), .rd_idx, .rd_seq, .inc(trl_go), .inc_idx(chan)
  );
  always_comb begin
    state_nx = hdr_go ? ST_PAYLOAD : (acc && s_axis.tlast) ? ST_TRAILER : trl_go ? ST_IDLE : state;
    hdr = '0;
    hdr[SYNC_LSB+:32] = SYNC_WORD;
    hdr[SEQ_LSB+:16] = 16'(rd_seq);
    hdr[CHAN_LSB+:8] = 8'(s_axis.tuser);
    trl = '0;
    trl[SYNC_LSB+:32] = ~SYNC_WORD;
    trl[CNT_LSB+:16] = 16'(beat_cnt);
    trl[OVF_BIT] = ovf;
    nx_data = hdr_go ? hdr : trl_go ? trl : s_axis.tdata;
  end
  always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
    if (!s_axis_rst_n) state <= ST_IDLE;
    else state <= state_nx;
  end
  // the beat count sticks at full scale and the overflow flag records the lost increment
  always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
    if (!s_axis_rst_n) begin
      chan <= '0;
      beat_cnt <= '0;
      ovf <= 1'b0;
    end else if (hdr_go) begin
      chan <= s_axis.tuser;
      beat_cnt <= '0;
      ovf <= 1'b0;
    end else if (acc) begin
      if (&beat_cnt) ovf <= 1'b1;
      else beat_cnt <= beat_cnt + 1'b1;
    end
  end
  always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
    if (!s_axis_rst_n) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_last <= 1'b0;
      m_user <= '0;
    end else if (load) begin
      m_valid <= hdr_go || acc || trl_go;
      if (hdr_go || acc || trl_go) begin
        m_data <= nx_data;
        m_last <= trl_go;
        m_user <= hdr_go ? s_axis.tuser : chan;
      end
    end
  end
endmodule
